// File: rtl/flappy_pkg.sv
// Shared constants for the FlappyBird scene renderer: screen size, palette, bird reset row.
package flappy_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    localparam logic [11:0] SKY      = 12'hFC6;
    localparam logic [11:0] PIPE     = 12'h2C2;
    localparam logic [11:0] GROUND_A = 12'h259;
    localparam logic [11:0] GROUND_B = 12'h147;
    localparam logic [11:0] BIRD     = 12'h0DF;
    localparam logic [11:0] GRID     = 12'hFFF;

    localparam logic [8:0] BIRD_RESET_Y = 9'd240;
    localparam logic [8:0] LAST_ROW     = 9'd479;

endpackage

// File: rtl/scene_renderer_if.sv
// Pixel request/response and game-state bus between vgac/game logic (master) and scene_renderer (slave).
interface scene_renderer_if #(parameter int NUM_PIPES = 3);
    logic [8:0]             row_addr;
    logic [9:0]             col_addr;
    logic                   read;
    logic [8:0]             bird_y;
    logic [10*NUM_PIPES-1:0] pipe_x;
    logic [9*NUM_PIPES-1:0]  gap_y;
    logic                   game_over;
    logic [11:0]            d_out_BGR;
    logic                   frame_tick;

    modport master (
        output row_addr, col_addr, read, bird_y, pipe_x, gap_y, game_over,
        input  d_out_BGR, frame_tick
    );

    modport slave (
        input  row_addr, col_addr, read, bird_y, pipe_x, gap_y, game_over,
        output d_out_BGR, frame_tick
    );
endinterface

// File: rtl/scene_renderer_pipe_hit.sv
// Combinational hit test for one pipe column: solid above the gap and below it down to the ground.
module pipe_hit
    import flappy_pkg::*;
#(
    parameter int unsigned PIPE_W   = 52,
    parameter int unsigned GAP_H    = 120,
    parameter int unsigned GROUND_Y = 432
) (
    input  logic [9:0] col,
    input  logic [8:0] row,
    input  logic [9:0] px,
    input  logic [8:0] gy,
    output logic       hit
);

    logic [10:0] col_w;
    logic [10:0] row_w;
    logic [10:0] px_w;
    logic [10:0] gy_w;

    assign col_w = {1'b0, col};
    assign row_w = {2'b00, row};
    assign px_w  = {1'b0, px};
    assign gy_w  = {2'b00, gy};

    // 11-bit compares so px+PIPE_W and gy+GAP_H never wrap
    always_comb begin
        hit = 1'b0;
        if ((px_w < 11'(SCREEN_W)) &&
            (col_w >= px_w) && (col_w < px_w + 11'(PIPE_W)) &&
            (row_w < 11'(GROUND_Y)) &&
            ((row_w < gy_w) || (row_w >= gy_w + 11'(GAP_H)))) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/scene_renderer.sv
// FlappyBird pixel source: shadowed game state committed at end of active video, 1-cycle pixel latency.
// Optional build macro DEBUG_GRID_EN overlays a 32-pixel white grid on the final pixel.
module scene_renderer
    import flappy_pkg::*;
#(
    parameter int unsigned NUM_PIPES   = 3,
    parameter int unsigned BIRD_X      = 160,
    parameter int unsigned BIRD_SIZE   = 16,
    parameter int unsigned PIPE_W      = 52,
    parameter int unsigned GAP_H       = 120,
    parameter int unsigned GROUND_Y    = 432,
    parameter int unsigned SCROLL_STEP = 2
) (
    input  logic             vga_clk,
    input  logic             clrn,
    scene_renderer_if.slave  bus
);

    logic                    read_q_r;
    logic                    frame_tick_r;
    logic [11:0]             d_out_r;
    logic [8:0]              sh_bird_y_r;
    logic [10*NUM_PIPES-1:0] sh_pipe_x_r;
    logic [9*NUM_PIPES-1:0]  sh_gap_y_r;
    logic                    sh_game_over_r;
    logic [3:0]              scroll_r;
    logic [4:0]              frame_cnt_r;

    logic                    commit_s;
    logic [NUM_PIPES-1:0]    pipe_hits_s;
    logic                    bird_hit_s;
    logic [10:0]             col_w_s;
    logic [10:0]             row_w_s;
    logic [10:0]             bird_w_s;
    logic [10:0]             ground_sum_s;
    logic [11:0]             colour_s;
    logic [11:0]             pix_s;

    // falling edge of active video on the last row closes the frame
    assign commit_s = read_q_r && !bus.read && (bus.row_addr == LAST_ROW);

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
        pipe_hit #(.PIPE_W(PIPE_W), .GAP_H(GAP_H), .GROUND_Y(GROUND_Y)) u_pipe_hit (
            .col (bus.col_addr),
            .row (bus.row_addr),
            .px  (sh_pipe_x_r[g*10 +: 10]),
            .gy  (sh_gap_y_r[g*9 +: 9]),
            .hit (pipe_hits_s[g])
        );
    end

    assign col_w_s      = {1'b0, bus.col_addr};
    assign row_w_s      = {2'b00, bus.row_addr};
    assign bird_w_s     = {2'b00, sh_bird_y_r};
    assign ground_sum_s = col_w_s + {7'b0000000, scroll_r};
    assign bird_hit_s   = (col_w_s >= 11'(BIRD_X)) && (col_w_s < 11'(BIRD_X + BIRD_SIZE)) &&
                          (row_w_s >= bird_w_s) && (row_w_s < bird_w_s + 11'(BIRD_SIZE));

    // priority colour select, blink inversion, optional grid overlay
    always_comb begin
        colour_s = SKY;
        pix_s    = SKY;
        if (bird_hit_s) begin
            colour_s = BIRD;
        end else if (|pipe_hits_s) begin
            colour_s = PIPE;
        end else if (row_w_s >= 11'(GROUND_Y)) begin
            colour_s = ground_sum_s[3] ? GROUND_B : GROUND_A;
        end else begin
            colour_s = SKY;
        end
        if (sh_game_over_r && frame_cnt_r[4]) begin
            pix_s = ~colour_s;
        end else begin
            pix_s = colour_s;
        end
`ifdef DEBUG_GRID_EN
        if ((bus.col_addr[4:0] == 5'd0) || (bus.row_addr[4:0] == 5'd0)) begin
            pix_s = GRID;
        end else begin
            pix_s = pix_s;
        end
`endif
    end

    // shadow commit, frame counters and registered pixel output
    always_ff @(posedge vga_clk or posedge clrn) begin
        if (clrn) begin
            read_q_r       <= 1'b0;
            frame_tick_r   <= 1'b0;
            d_out_r        <= 12'h000;
            sh_bird_y_r    <= BIRD_RESET_Y;
            sh_pipe_x_r    <= {NUM_PIPES{10'h3FF}};
            sh_gap_y_r     <= '0;
            sh_game_over_r <= 1'b0;
            scroll_r       <= 4'd0;
            frame_cnt_r    <= 5'd0;
        end else begin
            read_q_r     <= bus.read;
            frame_tick_r <= commit_s;
            d_out_r      <= bus.read ? pix_s : 12'h000;
            if (commit_s) begin
                sh_bird_y_r    <= bus.bird_y;
                sh_pipe_x_r    <= bus.pipe_x;
                sh_gap_y_r     <= bus.gap_y;
                sh_game_over_r <= bus.game_over;
                frame_cnt_r    <= frame_cnt_r + 5'd1;
                if (!bus.game_over) begin
                    scroll_r <= scroll_r + 4'(SCROLL_STEP);
                end
            end
        end
    end

    assign bus.d_out_BGR  = d_out_r;
    assign bus.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_scene_renderer.sv
// Randomized bench for scene_renderer against a frame-level behavioural model of the scene rules.
module tb_scene_renderer;

    localparam int NP = 3;

    logic vga_clk;
    logic clrn;

    scene_renderer_if #(.NUM_PIPES(NP)) bus ();

    scene_renderer #(.NUM_PIPES(NP)) dut (
        .vga_clk (vga_clk),
        .clrn    (clrn),
        .bus     (bus)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int n_vec;
    int n_mis;

    // live game state driven by the bench
    int l_bird_y;
    int l_pipe_x [NP];
    int l_gap_y  [NP];
    bit l_go;

    // model of committed state
    int m_bird_y;
    int m_pipe_x [NP];
    int m_gap_y  [NP];
    bit m_go;
    int m_scroll;
    int m_fcnt;
    bit m_read_q;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clampi(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [11:0] ref_pixel(int r, int c);
        logic [11:0] p;
        bit pipe;
        pipe = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (m_pipe_x[i] < 640 && c >= m_pipe_x[i] && c < m_pipe_x[i] + 52 && r < 432 &&
                (r < m_gap_y[i] || r >= m_gap_y[i] + 120))
                pipe = 1'b1;
        end
        if (c >= 160 && c < 176 && r >= m_bird_y && r < m_bird_y + 16) p = 12'h0DF;
        else if (pipe) p = 12'h2C2;
        else if (r >= 432) p = (((c + m_scroll) / 8) % 2 == 0) ? 12'h259 : 12'h147;
        else p = 12'hFC6;
        if (m_go && m_fcnt >= 16) p = ~p;
`ifdef DEBUG_GRID_EN
        if (c % 32 == 0 || r % 32 == 0) p = 12'hFFF;
`endif
        return p;
    endfunction

    task automatic model_reset();
        m_bird_y = 240;
        for (int i = 0; i < NP; i++) begin
            m_pipe_x[i] = 1023;
            m_gap_y[i]  = 0;
        end
        m_go     = 1'b0;
        m_scroll = 0;
        m_fcnt   = 0;
        m_read_q = 1'b0;
    endtask

    task automatic drive_live();
        bus.bird_y    = 9'(l_bird_y);
        bus.pipe_x    = {10'(l_pipe_x[2]), 10'(l_pipe_x[1]), 10'(l_pipe_x[0])};
        bus.gap_y     = {9'(l_gap_y[2]), 9'(l_gap_y[1]), 9'(l_gap_y[0])};
        bus.game_over = l_go;
    endtask

    task automatic scramble_live();
        l_bird_y = $urandom_range(0, 479);
        for (int i = 0; i < NP; i++) begin
            l_pipe_x[i] = ($urandom % 6 == 0) ? 1023 : $urandom_range(0, 700);
            l_gap_y[i]  = $urandom_range(0, 311);
        end
        drive_live();
    endtask

    // one pixel-clock cycle: apply inputs, advance model, check after the edge
    task automatic step(input bit rd, input int r, input int c);
        logic [11:0] exp_pix;
        bit exp_tick;
        bus.read     = rd;
        bus.row_addr = 9'(r);
        bus.col_addr = 10'(c);
        exp_pix  = rd ? ref_pixel(r, c) : 12'h000;
        exp_tick = m_read_q && !rd && (r == 479);
        if (exp_tick) begin
            m_bird_y = l_bird_y;
            for (int i = 0; i < NP; i++) begin
                m_pipe_x[i] = l_pipe_x[i];
                m_gap_y[i]  = l_gap_y[i];
            end
            m_go   = l_go;
            m_fcnt = (m_fcnt + 1) % 32;
            if (!m_go) m_scroll = (m_scroll + 2) % 16;
        end
        m_read_q = rd;
        @(posedge vga_clk);
        #1;
        chk_eq("pixel", {20'd0, bus.d_out_BGR}, {20'd0, exp_pix});
        chk_eq("frame_tick", {31'd0, bus.frame_tick}, {31'd0, exp_tick});
    endtask

    task automatic commit_frame();
        step(1'b1, 479, $urandom_range(0, 639));
        step(1'b0, 479, 0);
        step(1'b0, 0, 0);
    endtask

    task automatic pick(output int r, output int c);
        int sel;
        int i;
        sel = $urandom % 3;
        i   = $urandom % NP;
        if (sel == 0) begin
            c = clampi(158 + $urandom_range(0, 19), 0, 639);
            r = clampi(m_bird_y - 2 + $urandom_range(0, 19), 0, 479);
        end else if (sel == 1 && m_pipe_x[i] < 640) begin
            c = clampi(m_pipe_x[i] - 2 + $urandom_range(0, 55), 0, 639);
            r = ($urandom % 2 == 0) ? m_gap_y[i] : m_gap_y[i] + 120;
            r = clampi(r - 2 + $urandom_range(0, 3), 0, 479);
        end else begin
            c = $urandom_range(0, 639);
            r = ($urandom % 3 == 0) ? $urandom_range(425, 479) : $urandom_range(0, 479);
        end
    endtask

    initial begin
        int r;
        int c;
        bit rd;
        n_vec = 0;
        n_mis = 0;
        clrn  = 1'b1;
        bus.read = 1'b0;
        bus.row_addr = 9'd0;
        bus.col_addr = 10'd0;
        l_bird_y = 240;
        l_go     = 1'b0;
        for (int i = 0; i < NP; i++) begin
            l_pipe_x[i] = 1023;
            l_gap_y[i]  = 0;
        end
        drive_live();
        model_reset();
        repeat (3) @(posedge vga_clk);
        #1;
        chk_eq("reset_pixel", {20'd0, bus.d_out_BGR}, 32'h0);
        chk_eq("reset_tick", {31'd0, bus.frame_tick}, 32'h0);
        clrn = 1'b0;

        // defaults give sky, then read low gives zero
        step(1'b1, 100, 10);
        step(1'b0, 100, 11);

        // live bird move is invisible until the commit
        l_bird_y = 200;
        drive_live();
        step(1'b1, 200, 160);
        commit_frame();
        step(1'b1, 200, 160);

        // pipe edges and gap boundaries
        l_pipe_x[0] = 300;
        l_gap_y[0]  = 150;
        drive_live();
        commit_frame();
        step(1'b1, 149, 300);
        step(1'b1, 150, 300);
        step(1'b1, 270, 351);
        step(1'b1, 270, 352);

        // bird over a pipe, plus ground
        l_pipe_x[0] = 150;
        drive_live();
        commit_frame();
        step(1'b1, 200, 160);
        step(1'b1, 440, 0);
        step(1'b1, 64, 37);
        step(1'b1, 65, 37);

        for (int f = 0; f < 48; f++) begin
            l_go = (f >= 12 && f < 44);
            scramble_live();
            for (int k = 0; k < 30; k++) begin
                if ($urandom % 8 == 0) scramble_live();
                rd = ($urandom % 10) != 0;
                pick(r, c);
                if (!rd && r == 479) r = 478;
                step(rd, r, c);
                if (f == 30 && k == 10) begin
                    #2 clrn = 1'b1;
                    #1;
                    chk_eq("async_reset_pixel", {20'd0, bus.d_out_BGR}, 32'h0);
                    chk_eq("async_reset_tick", {31'd0, bus.frame_tick}, 32'h0);
                    model_reset();
                    #2 clrn = 1'b0;
                end
            end
            commit_frame();
            step(1'b1, $urandom_range(432, 479), $urandom_range(0, 639));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
